switch_packet_parser: RTL
=========================

SWITCH_PACKET_PARSER -- requirements
Module: switch_packet_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning the largest accepted payload length in bytes (1..255).
REQ-002 SHALL have port clock, input, 1, the single clock; all logic samples on posedge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_in, input, 8, the byte stream from the switch control side.
REQ-005 SHALL have port sw_enable_in, input, 1, byte-valid qualifier.
REQ-006 SHALL have port read_out, output, 1, high when the parser is idle and ready for a new packet.
REQ-007 SHALL have port out_valid, output, 1, payload byte strobe.
REQ-008 SHALL have port out_data, output, 8, payload byte.
REQ-009 SHALL have port out_last, output, 1, marks the final payload byte.
REQ-010 SHALL have ports pkt_da, pkt_sa and pkt_len, outputs, 8 each, the captured header fields, held until the next header.
REQ-011 SHALL have port pkt_done, output, 1, one-cycle pulse when a packet ends.
REQ-012 SHALL have port pkt_ok, output, 1, valid with pkt_done: parity matched and length was legal.

Function
REQ-013 SHALL accept a byte only on a clock edge where sw_enable_in=1; cycles with sw_enable_in=0 are stalls and leave all state unchanged.
REQ-014 SHALL use states IDLE, DA, SA, LEN, PAYLOAD, PARITY, DROP.
REQ-015 IDLE SHALL go to DA on an accepted 0xFF; any other accepted byte SHALL be discarded and the state SHALL stay IDLE.
REQ-016 DA, SA and LEN SHALL each capture one accepted byte into pkt_da, pkt_sa and pkt_len, then advance.
REQ-017 LEN SHALL go to PARITY if the length is 0, to DROP if the length is greater than MAX_LEN, and otherwise to PAYLOAD.
REQ-018 PAYLOAD SHALL emit each accepted byte on out_data with out_valid=1 one cycle after acceptance (registered).
REQ-019 PAYLOAD SHALL assert out_last with the byte whose count equals pkt_len, then go to PARITY.
REQ-020 An 8-bit down-counter loaded from the length SHALL track the remaining payload; it SHALL never wrap below 0.
REQ-021 The running parity SHALL be the XOR of DA, SA, LEN and all payload bytes.
REQ-022 PARITY SHALL compare the accepted byte with the running parity, pulse pkt_done one cycle later with pkt_ok=(match), and return to IDLE.
REQ-023 DROP SHALL consume pkt_len+1 accepted bytes with out_valid held 0, then pulse pkt_done with pkt_ok=0 and return to IDLE.
REQ-024 The 0xFF byte SHALL be treated as data whenever it arrives in any state other than IDLE; there SHALL be no resynchronisation mid-packet.
REQ-025 The byte following the parity byte (terminator 0x00) SHALL be handled by IDLE rules and therefore discarded.
REQ-026 read_out SHALL be 1 exactly when the state is IDLE.
REQ-027 out_valid and pkt_done SHALL never be asserted together.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state to IDLE, read_out=1, and all other outputs, counters and parity to 0.
REQ-029 A reset mid-packet SHALL abandon the packet with no pkt_done; the next accepted 0xFF after release SHALL start a fresh packet.

Structure
REQ-030 Package switch_rtl_pkg SHALL hold the state enum, SYNC_BYTE=8'hFF and the default MAX_LEN.
REQ-031 A sub-module switch_parity_acc SHALL provide the clear, enable and byte-in XOR accumulator.

Verification
REQ-032 Byte stream FF,01,02,02,10,20,31 with sw_enable_in=1 throughout SHALL yield out_data 10 then 20 (out_last on 20), pkt_da=01, pkt_sa=02, pkt_len=02, and pkt_done with pkt_ok=1.
REQ-033 The same stream with parity byte 30 SHALL still emit the payload, then pkt_done with pkt_ok=0.
REQ-034 The REQ-032 stream with sw_enable_in=0 for 3 cycles after SA SHALL produce identical outputs delayed by 3 cycles.
REQ-035 FF,01,02,00,03 SHALL produce no out_valid and pkt_done with pkt_ok=1.
REQ-036 With MAX_LEN=64, a length of 0x50 SHALL enter DROP, produce no out_valid, and after 81 accepted bytes give pkt_done with pkt_ok=0 and read_out=1.
REQ-037 reset_n pulsed low after the first payload byte SHALL force read_out=1 immediately with no pkt_done; a following REQ-032 stream SHALL parse correctly.

Source files
------------

// File: rtl/switch_packet_parser_pkg.sv
// Shared types and constants for the switch control-byte packet parser.
// Holds the parser state encoding, the sync byte and the default payload limit.
package switch_rtl_pkg;

    localparam int         DEFAULT_MAX_LEN = 64;
    localparam logic [7:0] SYNC_BYTE       = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DA      = 3'd1,
        SA      = 3'd2,
        LEN     = 3'd3,
        PAYLOAD = 3'd4,
        PARITY  = 3'd5,
        DROP    = 3'd6
    } state_t;

endpackage

// File: rtl/switch_packet_parser_if.sv
// Byte-stream and result bus between the switch control side and the parser.
// Handshake: a byte on data_in is taken on a rising clock edge only when sw_enable_in=1; there is no back-pressure, read_out is status only.
interface switch_packet_parser_if;
    import switch_rtl_pkg::*;

    logic [7:0] data_in;
    logic       sw_enable_in;
    logic       read_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] pkt_da;
    logic [7:0] pkt_sa;
    logic [7:0] pkt_len;
    logic       pkt_done;
    logic       pkt_ok;
    state_t     dbg_state;

    modport slave (
        input  data_in, sw_enable_in,
        output read_out, out_valid, out_data, out_last,
               pkt_da, pkt_sa, pkt_len, pkt_done, pkt_ok, dbg_state
    );

    modport master (
        output data_in, sw_enable_in,
        input  read_out, out_valid, out_data, out_last,
               pkt_da, pkt_sa, pkt_len, pkt_done, pkt_ok, dbg_state
    );

endinterface

// File: rtl/switch_packet_parser_parity_acc.sv
// Running XOR accumulator over header and payload bytes.
// Clear wins over enable so a new packet can start on the same edge.
module switch_parity_acc (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_byte,
    output logic [7:0] o_parity
);

    logic [7:0] r_parity;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 8'h00;
        end else if (i_clear) begin
            r_parity <= 8'h00;
        end else if (i_enable) begin
            r_parity <= r_parity ^ i_byte;
        end
    end

    assign o_parity = r_parity;

endmodule

// File: rtl/switch_packet_parser.sv
// Parses FF,DA,SA,LEN,payload,parity packets from the switch control stream.
// Payload bytes are re-emitted one cycle after acceptance; oversize packets are consumed silently.
module switch_packet_parser
    import switch_rtl_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                   clock,
    input  logic                   reset_n,
    switch_packet_parser_if.slave  bus
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     r_state;
    logic [7:0] r_remaining;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_out_last;
    logic [7:0] r_pkt_da;
    logic [7:0] r_pkt_sa;
    logic [7:0] r_pkt_len;
    logic       r_pkt_done;
    logic       r_pkt_ok;

    logic       w_accept;
    logic [7:0] w_byte;
    logic       w_par_clear;
    logic       w_par_enable;
    logic [7:0] w_parity;

    assign w_accept     = bus.sw_enable_in;
    assign w_byte       = bus.data_in;
    assign w_par_clear  = w_accept && (r_state == IDLE) && (w_byte == SYNC_BYTE);
    assign w_par_enable = w_accept && ((r_state == DA) || (r_state == SA) ||
                                       (r_state == LEN) || (r_state == PAYLOAD));

    switch_parity_acc u_parity_acc (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_par_clear),
        .i_enable (w_par_enable),
        .i_byte   (w_byte),
        .o_parity (w_parity)
    );

    // Strobes default low every edge; everything else only moves on an accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_remaining <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_pkt_da    <= 8'h00;
            r_pkt_sa    <= 8'h00;
            r_pkt_len   <= 8'h00;
            r_pkt_done  <= 1'b0;
            r_pkt_ok    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_ok    <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_state <= DA;
                        end
                    end
                    DA: begin
                        r_pkt_da <= w_byte;
                        r_state  <= SA;
                    end
                    SA: begin
                        r_pkt_sa <= w_byte;
                        r_state  <= LEN;
                    end
                    LEN: begin
                        r_pkt_len   <= w_byte;
                        r_remaining <= w_byte;
                        if (w_byte == 8'h00) begin
                            r_state <= PARITY;
                        end else if (w_byte > MAX_LEN_B) begin
                            r_state <= DROP;
                        end else begin
                            r_state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_byte;
                        r_out_last  <= (r_remaining == 8'd1);
                        if (r_remaining != 8'd0) begin
                            r_remaining <= r_remaining - 8'd1;
                        end
                        if (r_remaining <= 8'd1) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_pkt_done <= 1'b1;
                        r_pkt_ok   <= (w_byte == w_parity);
                        r_state    <= IDLE;
                    end
                    DROP: begin
                        // Counter runs len..0, so len+1 bytes (payload plus parity slot) are eaten.
                        if (r_remaining == 8'd0) begin
                            r_pkt_done <= 1'b1;
                            r_pkt_ok   <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_remaining <= r_remaining - 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.read_out  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.pkt_da    = r_pkt_da;
    assign bus.pkt_sa    = r_pkt_sa;
    assign bus.pkt_len   = r_pkt_len;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.pkt_ok    = r_pkt_ok;
    assign bus.dbg_state = r_state;

endmodule
